updown_counter_deb: RTL and testbench

- Generalised up/down counter for the board I/O path: two push-button channels (up, down), per-channel synchroniser, edge detection and optional hold-check debounce.
- Adds parametrised debounce time, programmable min/max limits, wrap or saturate mode, synchronous load and event flags.
- Sits between the raw button/switch pins and the LED/7-seg display logic.

---
 rtl/counter_pkg.sv | 12 +
 rtl/updown_counter_deb_if.sv | 28 ++
 rtl/button_debounce.sv | 92 +++++++++
 rtl/updown_counter_deb.sv | 94 +++++++++
 tb/tb_updown_counter_deb.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// Shared types and constants for the debounced up/down counter.
package counter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } deb_state_t;

    localparam int CLK_FREQ_HZ     = 50000000;
    localparam int DEB_CYCLES_50MS = 2500000;

endpackage

// File: rtl/updown_counter_deb_if.sv
// Control/status bundle between the board-side driver and the counter core.
interface updown_counter_deb_if #(
    parameter int COUNT_WIDTH = 8
);
    logic                   cnt_up;
    logic                   cnt_down;
    logic                   debounce_en;
    logic                   wrap_en;
    logic [COUNT_WIDTH-1:0] cnt_min;
    logic [COUNT_WIDTH-1:0] cnt_max;
    logic                   load;
    logic [COUNT_WIDTH-1:0] load_val;
    logic [COUNT_WIDTH-1:0] count;
    logic                   wrap_pulse;
    logic                   limit_hit;

    modport master (
        output cnt_up, cnt_down, debounce_en, wrap_en,
        output cnt_min, cnt_max, load, load_val,
        input  count, wrap_pulse, limit_hit
    );

    modport slave (
        input  cnt_up, cnt_down, debounce_en, wrap_en,
        input  cnt_min, cnt_max, load, load_val,
        output count, wrap_pulse, limit_hit
    );
endinterface

// File: rtl/button_debounce.sv
// One push-button channel: 2-flop synchroniser, rising-edge detect and an
// optional hold-check debounce FSM producing a one-cycle step pulse.
module button_debounce
    import counter_pkg::*;
#(
    parameter int DEB_CYCLES    = DEB_CYCLES_50MS,
    parameter int DEB_CNT_WIDTH = 22
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    input  logic debounce_en,
    output logic step
);

    localparam logic [DEB_CNT_WIDTH-1:0] TIMER_LAST = DEB_CNT_WIDTH'(DEB_CYCLES - 1);

    logic                     sync1_reg;
    logic                     s_reg;
    logic                     s_d_reg;
    logic [1:0]               settle_reg;
    logic                     armed_reg;
    deb_state_t               state_reg, state_next;
    logic [DEB_CNT_WIDTH-1:0] timer_reg, timer_next;
    logic                     rise;
    logic                     fsm_step;

    // A button held across reset release must not count: edges are only
    // accepted once a genuine low sample has passed through the synchroniser.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg  <= 1'b0;
            s_reg      <= 1'b0;
            s_d_reg    <= 1'b0;
            settle_reg <= 2'b00;
            armed_reg  <= 1'b0;
        end else begin
            sync1_reg  <= raw;
            s_reg      <= sync1_reg;
            s_d_reg    <= s_reg;
            settle_reg <= {settle_reg[0], 1'b1};
            armed_reg  <= armed_reg | (settle_reg[1] & ~s_reg);
        end
    end

    assign rise = s_reg & ~s_d_reg & armed_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            timer_reg <= '0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        fsm_step   = 1'b0;
        if (!debounce_en) begin
            state_next = IDLE;
            timer_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (rise) begin
                        state_next = WAIT;
                        timer_next = '0;
                    end
                end
                WAIT: begin
                    if (timer_reg == TIMER_LAST) begin
                        fsm_step   = s_reg;
                        timer_next = '0;
                        state_next = IDLE;
                    end else begin
                        timer_next = timer_reg + DEB_CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    timer_next = '0;
                end
            endcase
        end
    end

    assign step = debounce_en ? fsm_step : rise;

endmodule

// File: rtl/updown_counter_deb.sv
// Up/down counter fed by two debounced buttons, with limits, wrap/saturate
// behaviour, synchronous load and one-cycle wrap/limit event flags.
module updown_counter_deb
    import counter_pkg::*;
#(
    parameter int COUNT_WIDTH   = 8,
    parameter int DEB_CYCLES    = DEB_CYCLES_50MS,
    parameter int DEB_CNT_WIDTH = 22
) (
    input  logic                 clk,
    input  logic                 reset_n,
    updown_counter_deb_if.slave  bus
);

    logic [1:0]             raw_vec;
    logic [1:0]             step_vec;
    logic                   up_req;
    logic                   down_req;
    logic [COUNT_WIDTH-1:0] count_reg, count_next;
    logic                   wrap_reg, wrap_next;
    logic                   limit_reg, limit_next;

    assign raw_vec = {bus.cnt_down, bus.cnt_up};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            button_debounce #(
                .DEB_CYCLES    (DEB_CYCLES),
                .DEB_CNT_WIDTH (DEB_CNT_WIDTH)
            ) u_deb (
                .clk         (clk),
                .reset_n     (reset_n),
                .raw         (raw_vec[gi]),
                .debounce_en (bus.debounce_en),
                .step        (step_vec[gi])
            );
        end
    endgenerate

    assign up_req   = step_vec[0];
    assign down_req = step_vec[1];

    // Limit tests use >= / <= so a loaded out-of-range value is pulled to the
    // far limit when wrapping, or simply held when saturating.
    always_comb begin
        count_next = count_reg;
        wrap_next  = 1'b0;
        limit_next = 1'b0;
        if (bus.load) begin
            count_next = bus.load_val;
        end else if (up_req && down_req) begin
            count_next = count_reg;
        end else if (up_req) begin
            if (count_reg >= bus.cnt_max) begin
                if (bus.wrap_en) begin
                    count_next = bus.cnt_min;
                    wrap_next  = 1'b1;
                end else begin
                    limit_next = 1'b1;
                end
            end else begin
                count_next = count_reg + COUNT_WIDTH'(1);
            end
        end else if (down_req) begin
            if (count_reg <= bus.cnt_min) begin
                if (bus.wrap_en) begin
                    count_next = bus.cnt_max;
                    wrap_next  = 1'b1;
                end else begin
                    limit_next = 1'b1;
                end
            end else begin
                count_next = count_reg - COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
            wrap_reg  <= 1'b0;
            limit_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            wrap_reg  <= wrap_next;
            limit_reg <= limit_next;
        end
    end

    assign bus.count      = count_reg;
    assign bus.wrap_pulse = wrap_reg;
    assign bus.limit_hit  = limit_reg;

endmodule

// File: tb/tb_updown_counter_deb.sv
// Directed, table-driven check of updown_counter_deb with DEB_CYCLES=4.
module tb_updown_counter_deb;

    logic clk = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    updown_counter_deb_if #(.COUNT_WIDTH(8)) dut_if ();

    updown_counter_deb #(
        .COUNT_WIDTH   (8),
        .DEB_CYCLES    (4),
        .DEB_CNT_WIDTH (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (dut_if)
    );

    typedef struct packed {
        logic       ld;
        logic [7:0] ld_val;
        logic       wrap;
        logic [7:0] mn;
        logic [7:0] mx;
        logic       up;
        logic       dn;
        logic [7:0] exp_count;
        logic       exp_wrap;
        logic       exp_lim;
    } vec_t;

    vec_t vecs[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_state(input string name, input logic [7:0] c, input logic w, input logic l);
        check({name, ".count"}, 32'(dut_if.count), 32'(c));
        check({name, ".wrap"},  32'(dut_if.wrap_pulse), 32'(w));
        check({name, ".limit"}, 32'(dut_if.limit_hit), 32'(l));
    endtask

    // Bypass-mode press: count moves on the third edge after the first sample.
    task automatic press(input logic up, input logic dn);
        dut_if.cnt_up   = up;
        dut_if.cnt_down = dn;
        repeat (3) tick();
    endtask

    task automatic release_btn();
        dut_if.cnt_up   = 1'b0;
        dut_if.cnt_down = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 8'd42,  1'b1, 8'd3, 8'd5,   1'b0, 1'b0, 8'd42,  1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'd5,   1'b1, 8'd3, 8'd5,   1'b1, 1'b0, 8'd3,   1'b1, 1'b0};
        vecs[2]  = '{1'b1, 8'd3,   1'b1, 8'd3, 8'd5,   1'b0, 1'b1, 8'd5,   1'b1, 1'b0};
        vecs[3]  = '{1'b0, 8'd0,   1'b1, 8'd3, 8'd5,   1'b1, 1'b0, 8'd3,   1'b1, 1'b0};
        vecs[4]  = '{1'b0, 8'd0,   1'b1, 8'd3, 8'd5,   1'b1, 1'b0, 8'd4,   1'b0, 1'b0};
        vecs[5]  = '{1'b0, 8'd0,   1'b1, 8'd3, 8'd5,   1'b0, 1'b1, 8'd3,   1'b0, 1'b0};
        vecs[6]  = '{1'b1, 8'd255, 1'b0, 8'd0, 8'd255, 1'b1, 1'b0, 8'd255, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 8'd0,   1'b0, 8'd0, 8'd255, 1'b0, 1'b1, 8'd0,   1'b0, 1'b1};
        vecs[8]  = '{1'b0, 8'd0,   1'b0, 8'd0, 8'd255, 1'b1, 1'b0, 8'd1,   1'b0, 1'b0};
        vecs[9]  = '{1'b1, 8'd10,  1'b0, 8'd0, 8'd255, 1'b1, 1'b1, 8'd10,  1'b0, 1'b0};
        vecs[10] = '{1'b1, 8'd200, 1'b1, 8'd3, 8'd5,   1'b1, 1'b0, 8'd3,   1'b1, 1'b0};
        vecs[11] = '{1'b1, 8'd200, 1'b0, 8'd3, 8'd5,   1'b1, 1'b0, 8'd200, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 8'd0,   1'b1, 8'd3, 8'd5,   1'b0, 1'b1, 8'd5,   1'b1, 1'b0};
        vecs[13] = '{1'b1, 8'd0,   1'b0, 8'd3, 8'd5,   1'b1, 1'b0, 8'd1,   1'b0, 1'b0};
        vecs[14] = '{1'b1, 8'd7,   1'b1, 8'd7, 8'd7,   1'b1, 1'b0, 8'd7,   1'b1, 1'b0};
        vecs[15] = '{1'b1, 8'd7,   1'b0, 8'd7, 8'd7,   1'b0, 1'b1, 8'd7,   1'b0, 1'b1};

        reset_n            = 1'b0;
        dut_if.cnt_up      = 1'b0;
        dut_if.cnt_down    = 1'b0;
        dut_if.debounce_en = 1'b0;
        dut_if.wrap_en     = 1'b0;
        dut_if.cnt_min     = 8'd0;
        dut_if.cnt_max     = 8'd255;
        dut_if.load        = 1'b0;
        dut_if.load_val    = 8'd0;

        repeat (3) tick();
        check_state("reset", 8'd0, 1'b0, 1'b0);
        $display("reset: count=%0d", dut_if.count);
        reset_n = 1'b1;
        repeat (4) tick();

        // Bypass: held for 10 cycles, exactly one step at edge 3
        dut_if.cnt_up = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("bypass_edge%0d", i + 1), 32'(dut_if.count), (i >= 2) ? 32'd1 : 32'd0);
        end
        $display("bypass: count=%0d", dut_if.count);
        release_btn();

        // Debounce: a 2-cycle glitch must not count
        dut_if.debounce_en = 1'b1;
        dut_if.cnt_up = 1'b1;
        repeat (2) tick();
        dut_if.cnt_up = 1'b0;
        repeat (10) tick();
        check("deb_glitch", 32'(dut_if.count), 32'd1);
        $display("debounce glitch: count=%0d", dut_if.count);

        // Debounce: held 10 cycles, step at edge 7
        dut_if.cnt_up = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("deb_hold_edge%0d", i + 1), 32'(dut_if.count), (i >= 6) ? 32'd2 : 32'd1);
        end
        $display("debounce hold: count=%0d", dut_if.count);
        release_btn();

        // Disabling debounce mid-wait aborts the pending step
        dut_if.cnt_up = 1'b1;
        repeat (4) tick();
        dut_if.debounce_en = 1'b0;
        tick();
        dut_if.debounce_en = 1'b1;
        repeat (10) tick();
        check("deb_abort", 32'(dut_if.count), 32'd2);
        $display("debounce abort: count=%0d", dut_if.count);
        release_btn();

        // Table-driven limit/wrap/saturate vectors in bypass mode
        dut_if.debounce_en = 1'b0;
        for (int v = 0; v < 16; v++) begin
            dut_if.wrap_en = vecs[v].wrap;
            dut_if.cnt_min = vecs[v].mn;
            dut_if.cnt_max = vecs[v].mx;
            if (vecs[v].ld) begin
                dut_if.load     = 1'b1;
                dut_if.load_val = vecs[v].ld_val;
                tick();
                dut_if.load = 1'b0;
            end
            if (vecs[v].up || vecs[v].dn) begin
                press(vecs[v].up, vecs[v].dn);
                check_state($sformatf("vec%0d", v), vecs[v].exp_count, vecs[v].exp_wrap, vecs[v].exp_lim);
                tick();
                check_state($sformatf("vec%0d_after", v), vecs[v].exp_count, 1'b0, 1'b0);
                release_btn();
            end else begin
                check_state($sformatf("vec%0d", v), vecs[v].exp_count, 1'b0, 1'b0);
            end
            $display("vec %0d: count=%0d wrap=%0b limit=%0b", v, dut_if.count,
                     dut_if.wrap_pulse, dut_if.limit_hit);
        end

        // Load in the same cycle as an up request: load wins, step is dropped
        dut_if.wrap_en = 1'b0;
        dut_if.cnt_min = 8'd0;
        dut_if.cnt_max = 8'd255;
        dut_if.cnt_up  = 1'b1;
        repeat (2) tick();
        dut_if.load     = 1'b1;
        dut_if.load_val = 8'd77;
        tick();
        dut_if.load = 1'b0;
        check_state("load_vs_up", 8'd77, 1'b0, 1'b0);
        tick();
        check("load_vs_up_after", 32'(dut_if.count), 32'd77);
        $display("load vs up: count=%0d", dut_if.count);
        release_btn();

        // Reset during the debounce wait, button held through release
        dut_if.debounce_en = 1'b1;
        dut_if.cnt_up = 1'b1;
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        check_state("reset_mid_wait", 8'd0, 1'b0, 1'b0);
        tick();
        reset_n = 1'b1;
        repeat (12) tick();
        check("held_through_reset", 32'(dut_if.count), 32'd0);
        $display("held through reset: count=%0d", dut_if.count);
        release_btn();
        dut_if.cnt_up = 1'b1;
        repeat (10) tick();
        check("repress_after_reset", 32'(dut_if.count), 32'd1);
        $display("re-press after reset: count=%0d", dut_if.count);
        release_btn();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
